// File: rtl/sad_tree_min.sv
// Pipelined radix-4 SAD tree with window running-minimum tracker.
// Optional macro SAD_TREE_GATE_EN: data registers load only on valid stages.
module sad_tree_min #(
   parameter int N_ELEM = 256,
   parameter int IN_W   = 8,
   parameter int IDX_W  = 10,
   localparam int LVL   = $clog2(N_ELEM) / 2,
   localparam int SUM_W = IN_W + 2 * LVL
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [N_ELEM*IN_W-1:0]   ad,
   output logic                     sum_valid,
   output logic [SUM_W-1:0]         sum,
   output logic                     best_valid,
   output logic [SUM_W-1:0]         best_sad,
   output logic [IDX_W-1:0]         best_idx
);

`ifdef SAD_TREE_GATE_EN
   localparam bit GATE_EN = 1'b1;
`else
   localparam bit GATE_EN = 1'b0;
`endif

   logic [LVL:0] vld_p, first_p, last_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p   <= '0;
         first_p <= '0;
         last_p  <= '0;
      end else begin
         vld_p   <= {vld_p[LVL-1:0], in_valid};
         first_p <= {first_p[LVL-1:0], in_first};
         last_p  <= {last_p[LVL-1:0], in_last};
      end
   end

   // Level k holds N_ELEM/4^k partial sums, each IN_W+2k bits wide.
   for (genvar k = 0; k <= LVL; k++) begin : g_lvl
      localparam int CNT = N_ELEM >> (2 * k);
      localparam int W   = IN_W + 2 * k;
      logic [CNT*W-1:0] data;
      logic [CNT*W-1:0] nxt;
      logic             en;

      if (k == 0) begin : g_src
         assign nxt = ad;
         assign en  = in_valid;
      end else begin : g_add
         localparam int WP = W - 2;
         always_comb begin
            nxt = '0;
            for (int i = 0; i < CNT; i++) begin
               nxt[i*W +: W] = (W'(g_lvl[k-1].data[(4*i)*WP +: WP]) +
                                W'(g_lvl[k-1].data[(4*i+1)*WP +: WP])) +
                               (W'(g_lvl[k-1].data[(4*i+2)*WP +: WP]) +
                                W'(g_lvl[k-1].data[(4*i+3)*WP +: WP]));
            end
         end
         assign en = vld_p[k-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            data <= '0;
         else if (en || !GATE_EN)
            data <= nxt;
      end
   end

   assign sum       = g_lvl[LVL].data;
   assign sum_valid = vld_p[LVL];

   logic [IDX_W-1:0] cnt, idx_cur, run_idx, new_idx;
   logic [SUM_W-1:0] run_min, new_min;
   logic             take;

   // Strict compare keeps the earliest index on ties; a first tag always loads.
   always_comb begin
      idx_cur = first_p[LVL] ? '0 : cnt;
      take    = first_p[LVL] || (sum < run_min);
      new_min = take ? sum : run_min;
      new_idx = take ? idx_cur : run_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         run_min    <= '1;
         run_idx    <= '0;
         best_valid <= 1'b0;
         best_sad   <= '0;
         best_idx   <= '0;
      end else begin
         best_valid <= sum_valid && last_p[LVL];
         if (sum_valid) begin
            if (last_p[LVL]) begin
               best_sad <= new_min;
               best_idx <= new_idx;
               run_min  <= '1;
               run_idx  <= '0;
               cnt      <= '0;
            end else begin
               run_min  <= new_min;
               run_idx  <= new_idx;
               cnt      <= idx_cur + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/sad_tree_min.md
Name: sad_tree_min

Overview:
- Parametrised, pipelined radix-4 absolute-difference summation tree with valid tagging and a running-minimum tracker.
- Consumes one candidate's packed absolute differences per cycle and emits each candidate's SAD.
- Across a search window delimited by first/last tags, reports the minimum SAD and its candidate index.
- Sits between the PE array and the motion-vector controller in the full-search motion estimation processor.

Parameters:
- N_ELEM, 256, number of absolute-difference elements per candidate; must be a power of 4, at least 4.
- IN_W, 8, width of each absolute-difference element.
- IDX_W, 10, width of the candidate index counter.
- Derived: LVL = log4(N_ELEM), which is 4 at default. SUM_W = IN_W + 2*LVL, which is 16 at default.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ad carries a candidate this cycle
- in_first  in  1  first candidate of a search window; qualified by in_valid
- in_last  in  1  last candidate of a search window; qualified by in_valid
- ad  in  N_ELEM*IN_W  packed elements; element i is at ad[(i+1)*IN_W-1 : i*IN_W]
- sum_valid  out  1  sum is valid this cycle
- sum  out  SUM_W  SAD of one candidate
- best_valid  out  1  one-cycle pulse; window result is valid
- best_sad  out  SUM_W  minimum SAD of the completed window
- best_idx  out  IDX_W  index of the minimum-SAD candidate within its window

Behaviour:
- Reset: rst_n is asynchronous and active-low; the clock is clk.
  - All pipeline registers, sum, sum_valid, best_valid, best_sad, best_idx and the index counter clear to 0.
  - The internal running minimum resets to all-ones.
- Stage 0 registers ad unchanged.
- Stages 1..LVL each add groups of 4 operands as (a+b)+(c+d). Level k results are IN_W+2k bits wide, so no overflow is possible.
- Latency: ad sampled at cycle T appears on sum at T+LVL+1 (T+5 at default). Throughput is one candidate per cycle; no backpressure.
- in_valid, in_first and in_last travel in a shift pipeline alongside the data; sum_valid is the delayed in_valid.
- Index counter, updated on each sum_valid:
  - first tag set: current index = 0; counter becomes 1.
  - otherwise: current index = counter; counter increments modulo 2^IDX_W, wrapping silently.
- Running minimum, updated one cycle after the sum stage on each sum_valid:
  - first tag set: load sum and current index unconditionally.
  - otherwise: update only if sum < running minimum (strict). Ties keep the earlier index.
- Window completion (sum_valid with last tag):
  - Next cycle: best_valid=1, with best_sad/best_idx holding the minimum including that final candidate.
  - best_sad/best_idx then hold until the next window completes.
  - Running minimum returns to all-ones; counter returns to 0.
- first and last on the same candidate: a one-candidate window. Result is that SAD with best_idx=0.
- first arriving mid-window: discards the partial window and restarts; no best_valid for the abandoned window.
- Candidates without any preceding first: tracked against an all-ones minimum with indices from the counter, so results stay well defined.
- Non-valid cycles: the tracker and counter are unchanged. Gaps in in_valid are allowed anywhere.
- Reset mid-operation: all in-flight candidates are dropped; no sum_valid or best_valid is produced for them.

Optional Feature:
- Macro SAD_TREE_GATE_EN.
- Defined: each pipeline data register loads only when its stage's valid bit is set. sum and all stage registers hold their last valid value through bubbles, which saves toggle power.
- Undefined: data registers load every cycle; sum reflects whatever ad was sampled LVL+1 cycles earlier.
- Valid, tag, tracker and best_* behaviour are identical in both builds.

Test Plan:
- Defaults, all elements 255, single valid with first+last at cycle 0 -> sum=65280 with sum_valid at cycle 5; best_valid at cycle 6 with best_sad=65280, best_idx=0.
- Back-to-back window of 4 candidates, elements all 3, 1, 1, 2 (sums 768, 256, 256, 512), first on #0, last on #3 -> best_sad=256, best_idx=1 (tie keeps earlier); exactly one best_valid pulse.
- Same 4 candidates with 2-cycle in_valid gaps between them -> identical result; sum_valid pulses only for the 4 candidates.
- Window A (sums 100, 50), then window B (sums 300, 200) issued immediately -> best 50/idx1, then 200/idx1; no carry-over from A.
- in_first reasserted on the 3rd candidate of an open window -> no best_valid for the abandoned window; the result reports indices relative to the restart.
- rst_n pulsed low while 3 candidates are in flight -> outputs 0 immediately, no sum_valid afterward. With SAD_TREE_GATE_EN, sum holds 65280 through a 10-cycle bubble; without it, sum tracks the idle ad.
